biquad_coeff_wb_loader: RTL

//  Wishbone initiator that drives the WB target port of the pre-trigger filter chain (LPF + dual biquad).

---
 rtl/pueo_wb_pkg.sv | 20 ++
 rtl/coef_stage_ram.sv | 24 ++
 rtl/biquad_coeff_wb_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pueo_wb_pkg.sv
// Shared Wishbone loader types: error codes reported to software and loader FSM state encoding.
package pueo_wb_pkg;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_BUS         = 2'd1,
    ERR_TIMEOUT     = 2'd2,
    ERR_RETRY_ABORT = 2'd3
  } wb_err_code_t;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t LD_IDLE  = 3'd0;
  localparam loader_state_t LD_FETCH = 3'd1;
  localparam loader_state_t LD_REQ   = 3'd2;
  localparam loader_state_t LD_RETRY = 3'd3;
  localparam loader_state_t LD_FIN   = 3'd4;
  localparam loader_state_t LD_FAIL  = 3'd5;

endpackage

// File: rtl/coef_stage_ram.sv
// Coefficient staging table: simple dual-port RAM, one write port, registered read (1-cycle latency).
module coef_stage_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 54
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents are undefined until software loads them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/biquad_coeff_wb_loader.sv
// Replays the staged {address, data} table as single Wishbone writes into the filter chain and
// pulses coef_update_o once every write has been acknowledged.
module biquad_coeff_wb_loader
  import pueo_wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rstn_i,
  input  logic                       tbl_we_i,
  input  logic [$clog2(DEPTH)-1:0]   tbl_addr_i,
  input  logic [ADDR_W+DATA_W-1:0]   tbl_dat_i,
  input  logic [$clog2(DEPTH):0]     n_words_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [ADDR_W-1:0]          wb_adr_o,
  output logic [DATA_W-1:0]          wb_dat_o,
  output logic [DATA_W/8-1:0]        wb_sel_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  input  logic                       wb_rty_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [1:0]                 err_code_o,
  output logic [$clog2(DEPTH)-1:0]   err_index_o,
  output logic                       coef_update_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 2);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  loader_state_t      state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               abort_pend_q, abort_pend_d;
  logic               cyc_q, cyc_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic               busy_q, done_q;
  logic               error_q, error_d;
  wb_err_code_t       err_code_q, err_code_d;
  logic [IDX_W-1:0]   err_index_q, err_index_d;

  logic               fail;
  wb_err_code_t       fail_code;
  logic [ENT_W-1:0]   rd_data;
  logic [CNT_W-1:0]   idx_next;
  logic               abort_req;

  // Reads are addressed with the next index so the entry is already on rd_data during FETCH.
  coef_stage_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk   (wb_clk_i),
    .we    (tbl_we_i & ~busy_q),
    .waddr (tbl_addr_i),
    .wdata (tbl_dat_i),
    .raddr (idx_d),
    .rdata (rd_data)
  );

  assign idx_next  = {1'b0, idx_q} + CNT_W'(1);
  assign abort_req = abort_i | abort_pend_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    fail        = 1'b0;
    fail_code   = ERR_NONE;

    case (state_q)
      LD_IDLE: begin
        if (start_i) begin
          error_d     = 1'b0;
          err_code_d  = ERR_NONE;
          err_index_d = '0;
          if (n_words_i == '0) begin
            state_d = LD_FIN;
          end else begin
            count_d = (n_words_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n_words_i;
            idx_d   = '0;
            retry_d = '0;
            state_d = LD_FETCH;
          end
        end
      end
      LD_FETCH: begin
        if (abort_i) begin
          fail      = 1'b1;
          fail_code = ERR_RETRY_ABORT;
        end else begin
          {adr_d, dat_d} = rd_data;
          cyc_d          = 1'b1;
          tmo_d          = '0;
          state_d        = LD_REQ;
        end
      end
      LD_REQ: begin
        // Termination precedence: err, then rty, then ack; abort waits for a termination.
        if (wb_err_i) begin
          cyc_d     = 1'b0;
          fail      = 1'b1;
          fail_code = ERR_BUS;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (abort_req || (retry_q >= RTY_W'(MAX_RETRY))) begin
            fail      = 1'b1;
            fail_code = ERR_RETRY_ABORT;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = LD_RETRY;
          end
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          if (abort_req) begin
            fail      = 1'b1;
            fail_code = ERR_RETRY_ABORT;
          end else if (idx_next == count_q) begin
            state_d = LD_FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = LD_FETCH;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          cyc_d     = 1'b0;
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      LD_RETRY: begin
        if (abort_i) begin
          fail      = 1'b1;
          fail_code = ERR_RETRY_ABORT;
        end else begin
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = LD_REQ;
        end
      end
      LD_FIN:  state_d = LD_IDLE;
      LD_FAIL: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase

    if (fail) begin
      state_d     = LD_FAIL;
      error_d     = 1'b1;
      err_code_d  = fail_code;
      err_index_d = idx_q;
    end
  end

  // An abort seen mid-cycle is remembered until the target terminates the cycle.
  assign abort_pend_d = (state_q == LD_REQ) && (state_d == LD_REQ) && abort_req;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q      <= LD_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      abort_pend_q <= 1'b0;
      cyc_q        <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      abort_pend_q <= abort_pend_d;
      cyc_q        <= cyc_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      busy_q       <= (state_d != LD_IDLE);
      done_q       <= (state_d == LD_FIN);
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      err_index_q  <= err_index_d;
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = cyc_q;
  assign wb_sel_o      = {(DATA_W/8){cyc_q}};
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign coef_update_o = done_q;
  assign error_o       = error_q;
  assign err_code_o    = err_code_q;
  assign err_index_o   = err_index_q;

endmodule
